// File: rtl/frame_swap_writer.sv
// Purpose: turns the painter's pixel stream into bank-addressed frame-memory writes and swaps front/back banks on vsync.
// Latency: one cycle from a sampled in-range pixel to bram_we/bram_addr/bram_din; bank swap one cycle after vsync_start.
// Backpressure: none; every pixel is either written or dropped, and the painter is held in restart outside PAINT.
module frame_swap_writer #(
    parameter int COOR_WIDTH = 12,
    parameter int HSIZE      = 720,
    parameter int VSIZE      = 540,
    parameter int ADDR_WIDTH = 19
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [11:0]           pixel_data,
    input  logic [COOR_WIDTH-1:0] write_x,
    input  logic [COOR_WIDTH-1:0] write_y,
    input  logic                  painter_finished,
    input  logic                  vsync_start,
    output logic                  painter_rst,
    output logic                  bram_we,
    output logic                  bram_bank,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [11:0]           bram_din,
    output logic                  display_bank,
    output logic [7:0]            frame_count
);

    // Product wide enough for any y*HSIZE+x before truncation to the bank address.
    localparam int PROD_W = 2 * COOR_WIDTH + 2;

    typedef enum logic [1:0] {
        RESTART    = 2'd0,
        PAINT      = 2'd1,
        WAIT_VSYNC = 2'd2,
        SWAP       = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    we_nxt;
    logic                    in_range;
    logic [ADDR_WIDTH-1:0]   addr_lin;
    logic                    back_bank;

    // Range check on the full coordinate width, and the linear address of the current pixel.
    always_comb begin
        in_range = (32'(write_x) < 32'(HSIZE)) && (32'(write_y) < 32'(VSIZE));
        addr_lin = ADDR_WIDTH'(PROD_W'(write_y) * PROD_W'(HSIZE) + PROD_W'(write_x));
    end

    // Next-state and write-enable decode; the pixel in a painter_finished cycle is discarded.
    always_comb begin
        state_nxt = state;
        we_nxt    = 1'b0;
        case (state)
            RESTART: begin
                state_nxt = PAINT;
            end
            PAINT: begin
                if (painter_finished) begin
                    state_nxt = WAIT_VSYNC;
                end else begin
                    we_nxt = in_range;
                end
            end
            WAIT_VSYNC: begin
                if (vsync_start) begin
                    state_nxt = SWAP;
                end
            end
            SWAP: begin
                state_nxt = RESTART;
            end
            default: begin
                state_nxt = RESTART;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESTART;
        end else begin
            state <= state_nxt;
        end
    end

    // Write port registers (address/data hold while idle) plus bank and frame bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_we     <= 1'b0;
            bram_addr   <= '0;
            bram_din    <= '0;
            back_bank   <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            bram_we <= we_nxt;
            if (we_nxt) begin
                bram_addr <= addr_lin;
                bram_din  <= pixel_data;
            end
            if (state == SWAP) begin
                back_bank   <= ~back_bank;
                frame_count <= frame_count + 8'd1;
            end
        end
    end

    // Front bank is always the complement of the back bank, so they can never collide.
    assign bram_bank    = back_bank;
    assign display_bank = ~back_bank;
    assign painter_rst  = (state != PAINT);

endmodule

// File: tb/tb_frame_swap_writer.sv
// Randomized bench for frame_swap_writer with a scoreboard fed by a frame-level reference model.
// Expected outputs are queued by the driver each cycle and compared by an independent negedge monitor.
// Includes directed boundary pixels, finish/vsync coincidence, frame counter wrap and mid-write reset.
module tb_frame_swap_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] pixel_data;
    logic [11:0] write_x;
    logic [11:0] write_y;
    logic        painter_finished;
    logic        vsync_start;
    logic        painter_rst;
    logic        bram_we;
    logic        bram_bank;
    logic [18:0] bram_addr;
    logic [11:0] bram_din;
    logic        display_bank;
    logic [7:0]  frame_count;

    frame_swap_writer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pixel_data       (pixel_data),
        .write_x          (write_x),
        .write_y          (write_y),
        .painter_finished (painter_finished),
        .vsync_start      (vsync_start),
        .painter_rst      (painter_rst),
        .bram_we          (bram_we),
        .bram_bank        (bram_bank),
        .bram_addr        (bram_addr),
        .bram_din         (bram_din),
        .display_bank     (display_bank),
        .frame_count      (frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [18:0] addr;
        logic [11:0] din;
        logic        bank;
        logic        disp;
        logic [7:0]  fc;
        logic        prst;
    } exp_t;

    exp_t q[$];
    exp_t m;
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    // Reference model: painting / waiting-for-vsync flags and a countdown of
    // restart cycles still owed to the painter after a vsync (or after reset).
    bit m_paint;
    bit m_wait;
    int m_cd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_paint = 1'b0;
        m_wait  = 1'b0;
        m_cd    = 1;
        m.we    = 1'b0;
        m.addr  = '0;
        m.din   = '0;
        m.bank  = 1'b0;
        m.disp  = 1'b1;
        m.fc    = 8'd0;
        m.prst  = 1'b1;
    endfunction

    // Advance the model over one clock edge given the inputs sampled on that edge.
    function automatic void model_step(input logic [11:0] pix, input logic [11:0] x,
                                       input logic [11:0] y, input logic fin, input logic vs);
        m.we = 1'b0;
        if (m_paint) begin
            if (fin) begin
                m_paint = 1'b0;
                m_wait  = 1'b1;
            end else if (x < 12'd720 && y < 12'd540) begin
                m.we   = 1'b1;
                m.addr = 19'(int'(y) * 720 + int'(x));
                m.din  = pix;
            end
        end else if (m_wait) begin
            if (vs) begin
                m_wait = 1'b0;
                m_cd   = 2;
            end
        end else if (m_cd == 2) begin
            m.bank = ~m.bank;
            m.fc   = m.fc + 8'd1;
            m_cd   = 1;
        end else begin
            m_cd    = 0;
            m_paint = 1'b1;
        end
        m.disp = ~m.bank;
        m.prst = !m_paint;
    endfunction

    // One clock: account for the edge just taken, queue its expected outputs, drive new inputs.
    task automatic cyc(input logic [11:0] pix, input logic [11:0] x, input logic [11:0] y,
                       input logic fin, input logic vs);
        @(posedge clk);
        #1;
        model_step(pixel_data, write_x, write_y, painter_finished, vsync_start);
        q.push_back(m);
        pixel_data       = pix;
        write_x          = x;
        write_y          = y;
        painter_finished = fin;
        vsync_start      = vs;
    endtask

    task automatic rnd_cyc(input logic fin, input logic vs);
        logic [11:0] x;
        logic [11:0] y;
        x = ($urandom % 8 == 0) ? 12'($urandom) : 12'($urandom_range(0, 760));
        y = ($urandom % 8 == 0) ? 12'($urandom) : 12'($urandom_range(0, 560));
        cyc(12'($urandom), x, y, fin, vs);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        model_reset();
        q.push_back(m);
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: compares DUT outputs against queued expectations mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                chk("bram_we",      32'(bram_we),      32'(mon_e.we));
                chk("bram_addr",    32'(bram_addr),    32'(mon_e.addr));
                chk("bram_din",     32'(bram_din),     32'(mon_e.din));
                chk("bram_bank",    32'(bram_bank),    32'(mon_e.bank));
                chk("display_bank", 32'(display_bank), 32'(mon_e.disp));
                chk("frame_count",  32'(frame_count),  32'(mon_e.fc));
                chk("painter_rst",  32'(painter_rst),  32'(mon_e.prst));
                chk("bank_differ",  32'(display_bank ^ bram_bank), 32'd1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n            = 1'b0;
        pixel_data       = '0;
        write_x          = '0;
        write_y          = '0;
        painter_finished = 1'b0;
        vsync_start      = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        release_reset();

        // Directed pixels: nominal, last in-frame, first out-of-range column/row, far out.
        cyc(12'hABC, 12'd3,    12'd2,    1'b0, 1'b0);
        cyc(12'h123, 12'd719,  12'd539,  1'b0, 1'b0);
        cyc(12'h456, 12'd720,  12'd0,    1'b0, 1'b0);
        cyc(12'h789, 12'd0,    12'd540,  1'b0, 1'b0);
        cyc(12'hFED, 12'd4095, 12'd4095, 1'b0, 1'b0);
        cyc(12'h321, 12'd0,    12'd0,    1'b0, 1'b0);

        // Finish with an in-range pixel that must be discarded; vsync 10 cycles later.
        cyc(12'h777, 12'd5, 12'd5, 1'b1, 1'b0);
        repeat (9) rnd_cyc(1'b0, 1'b0);
        rnd_cyc(1'b0, 1'b1);
        repeat (4) rnd_cyc(1'b0, 1'b0);

        // Finish and vsync together: that vsync is ignored, the next one swaps.
        rnd_cyc(1'b1, 1'b1);
        repeat (5) rnd_cyc(1'b0, 1'b0);
        rnd_cyc(1'b0, 1'b1);
        repeat (4) rnd_cyc(1'b0, 1'b0);

        // Enough frames to bring the counter through 255 back to 0.
        for (int f = 0; f < 254; f++) begin
            repeat (3) rnd_cyc(1'b0, 1'b0);
            rnd_cyc(1'b1, 1'b0);
            repeat ($urandom_range(0, 3)) rnd_cyc(1'b0, 1'b0);
            rnd_cyc(1'b0, 1'b1);
            repeat (2) rnd_cyc(1'b0, 1'b0);
        end

        // Free-running random traffic, including stray finish/vsync pulses.
        repeat (1500) rnd_cyc(1'($urandom % 40 == 0), 1'($urandom % 6 == 0));

        // Steer back into painting (bounded), then reset while a write is on the port.
        for (int i = 0; i < 20 && !m_paint; i++) rnd_cyc(1'b0, 1'b1);
        chk("reached_paint", 32'(m_paint), 32'd1);
        cyc(12'h5A5, 12'd10, 12'd10, 1'b0, 1'b0);
        cyc(12'h000, 12'd0,  12'd0,  1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("pre_rst_we", 32'(bram_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_we",      32'(bram_we),      32'd0);
        chk("rst_addr",    32'(bram_addr),    32'd0);
        chk("rst_din",     32'(bram_din),     32'd0);
        chk("rst_bank",    32'(bram_bank),    32'd0);
        chk("rst_disp",    32'(display_bank), 32'd1);
        chk("rst_fc",      32'(frame_count),  32'd0);
        chk("rst_prst",    32'(painter_rst),  32'd1);
        model_reset();
        pixel_data       = '0;
        write_x          = '0;
        write_y          = '0;
        painter_finished = 1'b0;
        vsync_start      = 1'b0;
        repeat (2) @(posedge clk);
        release_reset();
        cyc(12'hABC, 12'd3, 12'd2, 1'b0, 1'b0);
        repeat (3) rnd_cyc(1'b0, 1'b0);

        repeat (3) @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_swap_writer.md
Name: frame_swap_writer

Overview:
- Sits directly downstream of the scene painter.
- Takes the painter's per-cycle pixel stream (colour plus x/y coordinate) and turns it into registered write transactions into a double-buffered frame memory (two banks).
- When the painter signals frame completion, it waits for the display's vsync, swaps the front and back banks, then pulses a restart to the painter so the next frame is drawn into the new back bank.

Parameters:
COOR_WIDTH, 12, width of write_x/write_y coordinates
HSIZE, 720, visible frame width in pixels
VSIZE, 540, visible frame height in pixels
ADDR_WIDTH, 19, per-bank linear address width (HSIZE*VSIZE = 388800 < 2^19)

Ports:
clk  input  1  system clock; all logic on posedge
rst_n  input  1  asynchronous, active-low reset
pixel_data  input  12  RGB444 pixel from painter
write_x  input  COOR_WIDTH  pixel column from painter
write_y  input  COOR_WIDTH  pixel row from painter
painter_finished  input  1  one-cycle pulse: painter completed the frame
vsync_start  input  1  one-cycle pulse from display timing (same clk domain): start of vertical blank
painter_rst  output  1  active-high restart to painter; held high except while painting
bram_we  output  1  frame-memory write enable
bram_bank  output  1  bank being written (back buffer)
bram_addr  output  ADDR_WIDTH  linear write address
bram_din  output  12  write data
display_bank  output  1  bank the display reads (front buffer)
frame_count  output  8  completed swaps, wraps 255->0

Behaviour:
- Reset (rst_n low, async): state=RESTART, painter_rst=1, bram_we=0, bram_addr=0, bram_din=0, bram_bank=0, display_bank=1, frame_count=0. An in-flight write is abandoned immediately; bram_we falls with rst_n, not on a clock edge.
- States: RESTART, PAINT, WAIT_VSYNC, SWAP.
- RESTART: painter_rst=1 for exactly one cycle, then go to PAINT.
- PAINT:
  - painter_rst=0.
  - Each cycle the input pixel is sampled.
  - If write_x<HSIZE and write_y<VSIZE: next cycle bram_we=1, bram_addr=write_y*HSIZE+write_x, bram_din=pixel_data, bram_bank=current back bank.
  - Otherwise next cycle bram_we=0 (pixel dropped).
  - Latency is one cycle, fixed, with no backpressure.
  - On painter_finished: the pixel sampled in that same cycle is discarded, painter_rst=1 next cycle, go to WAIT_VSYNC.
- WAIT_VSYNC:
  - bram_we=0, painter_rst=1.
  - On vsync_start, go to SWAP.
  - A vsync_start arriving in the same cycle as painter_finished (still in PAINT) is ignored; the swap waits for the next vsync.
- SWAP (one cycle):
  - display_bank <= back bank.
  - Back bank (bram_bank) <= old display_bank.
  - frame_count <= frame_count+1.
  - Go to RESTART.
- Invariant: display_bank != bram_bank at all times outside reset.
- Address arithmetic:
  - Constant multiply by HSIZE computed at full precision, then truncated to ADDR_WIDTH.
  - Range checks use unsigned compares on the full COOR_WIDTH inputs.
- painter_finished is ignored outside PAINT. vsync_start is ignored outside WAIT_VSYNC.
- bram_addr and bram_din hold their last values when bram_we=0.

Test Plan:
- Reset release, then pixel (x=3, y=2, data=0xABC) in PAINT -> next cycle bram_we=1, bram_addr=1443, bram_din=0xABC, bram_bank=0, display_bank=1.
- Pixels (719,539) and (720,0) on consecutive cycles -> first gives bram_addr=388799 with we=1; second gives we=0.
- painter_finished pulse, vsync_start 10 cycles later:
  - bram_we=0 throughout the wait.
  - One cycle after vsync: SWAP, giving display_bank=0, bram_bank=1, frame_count=1.
  - Then painter_rst high for 1 more cycle (RESTART), then 0.
- painter_finished and vsync_start in the same cycle -> no swap; swap occurs only on the following vsync_start; frame_count increments once.
- 256 complete frame/vsync cycles -> frame_count wraps to 0; banks alternate every frame.
- rst_n asserted mid-PAINT with bram_we=1 -> bram_we=0 before the next clock edge; all outputs at reset values; painter_rst=1.
